// File: rtl/pll_rst_seq_if.sv
// rtl/pll_rst_seq_if.sv - PLL control/status bundle between the reset sequencer and its environment
interface pll_rst_seq_if;
  logic       stdby_req;
  logic       pll_extlock;
  logic       pll_reset;
  logic       pll_stdby;
  logic       sys_rst_n;
  logic       pll_locked;
  logic       lock_fail;
  logic [7:0] retry_cnt;

  // Environment side: drives the standby request and the raw PLL lock
  modport master (
    output stdby_req, pll_extlock,
    input  pll_reset, pll_stdby, sys_rst_n, pll_locked, lock_fail, retry_cnt
  );

  // Sequencer side
  modport slave (
    input  stdby_req, pll_extlock,
    output pll_reset, pll_stdby, sys_rst_n, pll_locked, lock_fail, retry_cnt
  );
endinterface

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset/lock sequencer; PLL_LOCK_GLITCH_FILTER_EN enables the RUN-state lock glitch filter
module pll_rst_seq #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 24,
  parameter int LOCK_TIMEOUT_CYCLES = 24000,
  parameter int LOCK_STABLE_CYCLES  = 2400,
  parameter int MAX_RETRIES         = 8,
  parameter int GLITCH_CYCLES       = 4
) (
  input logic          clk,
  input logic          rst_n,
  pll_rst_seq_if.slave bus
);
  // One counter serves every timed phase, so it is sized for the longest one
  localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_B   = (LOCK_STABLE_CYCLES > GLITCH_CYCLES) ? LOCK_STABLE_CYCLES : GLITCH_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    STDBY
  } state_t;

  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;
  logic                   lock_loss;
  logic [7:0]             retry_q, retry_d, retry_inc;
  logic                   fail_q, fail_d;
  logic                   pll_reset_q, pll_stdby_q, sys_rst_n_q, pll_locked_q;

  assign lock_s    = sync[SYNC_STAGES-1];
  assign retry_inc = (retry_q == 8'hff) ? retry_q : retry_q + 8'd1;

  // extlock comes straight from the PLL analog block, so bring it into clk through a flop chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[SYNC_STAGES-2:0], bus.pll_extlock};
  end

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES + 1) : 1;
  logic [GW-1:0] glitch_cnt;

  // Count consecutive low lock samples while running; any high sample forgives the dropout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         glitch_cnt <= '0;
    else if (state != RUN || lock_s)    glitch_cnt <= '0;
    else if (!lock_loss)                glitch_cnt <= glitch_cnt + GW'(1);
  end

  assign lock_loss = !lock_s && (glitch_cnt == GW'(GLITCH_CYCLES - 1));
`else
  assign lock_loss = !lock_s;
`endif

  // Next-state and retry bookkeeping; standby wins over lock loss in RUN
  always_comb begin
    state_d = state;
    retry_d = retry_q;
    fail_d  = fail_q;
    case (state)
      PLL_RST:   if (cnt == PR_LAST) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt == TO_LAST) begin
          state_d = PLL_RST;
          retry_d = retry_inc;
          if (32'(retry_inc) >= MAX_RETRIES) fail_d = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s)              state_d = WAIT_LOCK;
        else if (cnt == ST_LAST)  state_d = RUN;
      end
      RUN: begin
        if (bus.stdby_req)        state_d = STDBY;
        else if (lock_loss)       state_d = WAIT_LOCK;
      end
      STDBY:     if (!bus.stdby_req) state_d = PLL_RST;
      default:   state_d = PLL_RST;
    endcase
  end

  // State, shared counter and outputs; outputs decode the next state so they switch on the transition edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= PLL_RST;
      cnt          <= '0;
      pll_reset_q  <= 1'b1;
      pll_stdby_q  <= 1'b0;
      sys_rst_n_q  <= 1'b0;
      pll_locked_q <= 1'b0;
      retry_q      <= 8'd0;
      fail_q       <= 1'b0;
    end else begin
      state        <= state_d;
      if (state_d != state)  cnt <= '0;
      else if (cnt != '1)    cnt <= cnt + CNT_W'(1);
      pll_reset_q  <= (state_d == PLL_RST);
      pll_stdby_q  <= (state_d == STDBY);
      sys_rst_n_q  <= (state_d == RUN);
      pll_locked_q <= (state_d == RUN);
      retry_q      <= retry_d;
      fail_q       <= fail_d;
    end
  end

  assign bus.pll_reset  = pll_reset_q;
  assign bus.pll_stdby  = pll_stdby_q;
  assign bus.sys_rst_n  = sys_rst_n_q;
  assign bus.pll_locked = pll_locked_q;
  assign bus.lock_fail  = fail_q;
  assign bus.retry_cnt  = retry_q;
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - directed vector table plus randomized run against a phase-level model
module tb_pll_rst_seq;
  localparam int PR = 4;
  localparam int TO = 32;
  localparam int ST = 16;
  localparam int MR = 3;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int GE = 4;
`else
  localparam int GE = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  pll_rst_seq_if bus();

  pll_rst_seq #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(PR), .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES(ST), .MAX_RETRIES(MR), .GLITCH_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int         grp;
    bit         rn;
    bit         sb;
    bit         ex;
    int         n;
    logic [12:0] exp;
  } vec_t;
  vec_t tv[$];

  // {pll_reset, pll_stdby, sys_rst_n, pll_locked, lock_fail, retry_cnt}
  function automatic logic [12:0] o(bit r, bit s, bit on, bit f, int rc);
    return {r, s, on, on, f, 8'(rc)};
  endfunction

  function automatic void add(int g, bit rn, bit sb, bit ex, int n, logic [12:0] e);
    vec_t v;
    v.grp = g; v.rn = rn; v.sb = sb; v.ex = ex; v.n = n; v.exp = e;
    tv.push_back(v);
  endfunction

  function automatic logic [12:0] act();
    return {bus.pll_reset, bus.pll_stdby, bus.sys_rst_n, bus.pll_locked, bus.lock_fail, bus.retry_cnt};
  endfunction

  task automatic chk(input string nm, input logic [12:0] a, input logic [12:0] e);
    n_checks++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %b required %b", nm, a, e);
  endtask

  task automatic drive(input bit rn, input bit sb, input bit ex);
    rst_n = rn;
    bus.stdby_req = sb;
    bus.pll_extlock = ex;
  endtask

  // Phase-level model: 0 reset pulse, 1 waiting for lock, 2 qualifying lock, 3 running, 4 standby
  int       mp = 0, mt = 0, mg = 0, m_retry = 0;
  bit       m_fail = 1'b0;
  bit [1:0] mh = 2'b00;

  task automatic model_step();
    bit ls;
    int np;
    ls = mh[1];
    mh = {mh[0], bus.pll_extlock};
    np = mp;
    if (mp != 3) mg = 0;
    case (mp)
      0: if (mt == PR - 1) np = 1;
      1: if (ls) np = 2;
         else if (mt == TO - 1) begin
           np = 0;
           if (m_retry < 255) m_retry++;
           if (m_retry >= MR) m_fail = 1'b1;
         end
      2: if (!ls) np = 1; else if (mt == ST - 1) np = 3;
      3: begin
           mg = ls ? 0 : mg + 1;
           if (bus.stdby_req) np = 4; else if (mg >= GE) np = 1;
         end
      default: if (!bus.stdby_req) np = 0;
    endcase
    if (np != mp) begin mp = np; mt = 0; end
    else mt++;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mp = 0; mt = 0; mg = 0; mh = 2'b00; m_retry = 0; m_fail = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [12:0] RUN0, O0, RST0, SB0;
    int seg;
    bit ex_r, sb_r;
    RUN0 = o(0,0,1,0,0); O0 = o(0,0,0,0,0); RST0 = o(1,0,0,0,0); SB0 = o(0,1,0,0,0);

    add(0, 0,0,0, 3, RST0);
    // bring-up: 4-cycle reset pulse, lock at cycle 10, release on 19th edge
    add(1, 1,0,0, 3, RST0);
    add(1, 1,0,0, 1, O0);
    add(1, 1,0,0, 9, O0);
    add(1, 1,0,1, 18, O0);
    add(1, 1,0,1, 1, RUN0);
    // lock dropout in RUN
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    add(4, 1,0,0, 1, RUN0);
    add(4, 1,0,1, 5, RUN0);
`endif
    add(4, 1,0,0, GE, RUN0);
    add(4, 1,0,1, 1, RUN0);
    add(4, 1,0,1, 1, O0);
    add(4, 1,0,1, 16, O0);
    add(4, 1,0,1, 1, RUN0);
    // standby together with lock loss, then resequence
    add(5, 1,1,0, 1, SB0);
    add(5, 1,1,0, 3, SB0);
    add(5, 1,0,1, 1, RST0);
    add(5, 1,0,1, 3, RST0);
    add(5, 1,0,1, 1, O0);
    add(5, 1,0,1, 16, O0);
    add(5, 1,0,1, 1, RUN0);
    // lock glitch during qualification restarts it without a PLL reset
    add(3, 1,1,1, 1, SB0);
    add(3, 1,0,1, 1, RST0);
    add(3, 1,0,1, 3, RST0);
    add(3, 1,0,1, 1, O0);
    add(3, 1,0,1, 9, O0);
    add(3, 1,0,0, 1, O0);
    add(3, 1,0,1, 1, O0);
    add(3, 1,0,1, 1, O0);
    add(3, 1,0,1, 16, O0);
    add(3, 1,0,1, 1, RUN0);
    // no lock: timeouts every 36 cycles, retry 1..3, sticky fail, then relock
    add(2, 1,0,0, GE + 1, RUN0);
    add(2, 1,0,0, 1, O0);
    for (int k = 1; k <= 3; k++) begin
      add(2, 1,0,0, 31, o(0,0,0,0,k-1) | o(0,0,0,(k-1) >= MR,0));
      add(2, 1,0,0, 1, o(1,0,0,k >= MR,k));
      add(2, 1,0,0, 3, o(1,0,0,k >= MR,k));
      add(2, 1,0,0, 1, o(0,0,0,k >= MR,k));
    end
    add(2, 1,0,1, 18, o(0,0,0,1,3));
    add(2, 1,0,1, 1, o(0,0,1,1,3));
    // reset asserted mid-qualification
    add(6, 1,0,0, GE, o(0,0,1,1,3));
    add(6, 1,0,1, 1, o(0,0,1,1,3));
    add(6, 1,0,1, 1, o(0,0,0,1,3));
    add(6, 1,0,1, 5, o(0,0,0,1,3));
    add(6, 0,0,1, 0, RST0);
    add(6, 0,0,1, 2, RST0);
    add(6, 1,0,1, 3, RST0);
    add(6, 1,0,1, 1, O0);
    add(6, 1,0,1, 16, O0);
    add(6, 1,0,1, 1, RUN0);

    foreach (tv[i]) begin
      drive(tv[i].rn, tv[i].sb, tv[i].ex);
      if (tv[i].n == 0) #1;
      else repeat (tv[i].n) @(negedge clk);
      chk($sformatf("dir_t%0d_row%0d", tv[i].grp, i), act(), tv[i].exp);
    end

    // randomized run compared every cycle against the phase model
    @(negedge clk);
    drive(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seg = 0; ex_r = 1'b0; sb_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk($sformatf("rand_c%0d", c), act(),
          {mp == 0, mp == 4, mp == 3, mp == 3, m_fail, 8'(m_retry)});
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
      if (seg == 0) begin
        ex_r = ($urandom_range(0, 9) < 7);
        seg  = ex_r ? $urandom_range(1, 80) : $urandom_range(1, 45);
      end
      seg--;
      if (!sb_r && $urandom_range(0, 99) == 0) sb_r = 1'b1;
      else if (sb_r && $urandom_range(0, 7) == 0) sb_r = 1'b0;
      bus.pll_extlock = ex_r;
      bus.stdby_req   = sb_r;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset and lock sequencer for the system PLL. Runs on the free-running 24 MHz board reference clock, which is the same clock that feeds the PLL's refclk input.
- Drives the PLL's active-high reset and stdby pins and consumes its extlock output.
- Produces one clean active-low system reset that releases only after the PLL has held lock for a qualified period. It re-sequences the PLL automatically on lock loss or lock timeout.

Parameters:
- SYNC_STAGES, 2: flops in the extlock synchroniser (minimum 2).
- PLL_RST_CYCLES, 24: cycles pll_reset is held high per reset pulse (1 us at 24 MHz).
- LOCK_TIMEOUT_CYCLES, 24000: cycles to wait for lock before re-pulsing pll_reset (1 ms).
- LOCK_STABLE_CYCLES, 2400: cycles lock must stay high continuously before sys_rst_n releases (100 us).
- MAX_RETRIES, 8: timeout count at which lock_fail is set.
- GLITCH_CYCLES, 4: consecutive low samples needed to declare lock loss (used only with the optional feature).

Ports:
- clk  in  1  24 MHz reference clock, same net as the PLL refclk.
- rst_n  in  1  asynchronous active-low reset.
- stdby_req  in  1  request PLL standby; synchronous to clk.
- pll_extlock  in  1  raw PLL extlock; asynchronous to clk.
- pll_reset  out  1  to PLL reset pin, active high.
- pll_stdby  out  1  to PLL stdby pin, active high.
- sys_rst_n  out  1  active-low reset for logic clocked by the PLL outputs.
- pll_locked  out  1  high while in RUN.
- lock_fail  out  1  sticky; set once retry_cnt reaches MAX_RETRIES.
- retry_cnt  out  8  number of lock timeouts; saturates at 255.

Behaviour:
- All outputs are registered.
- Reset state (rst_n low, asynchronous): state=PLL_RST, counter=0, pll_reset=1, pll_stdby=0, sys_rst_n=0, pll_locked=0, lock_fail=0, retry_cnt=0, synchroniser flops cleared to 0.
- lock_s is the output of the last synchroniser flop.
- One shared counter, cleared on every state change. Its width is sized for the largest cycle parameter.
- PLL_RST state:
  - pll_reset=1, sys_rst_n=0.
  - When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK state:
  - pll_reset=0, sys_rst_n=0.
  - If lock_s=1, go to STABLE.
  - Otherwise, when counter==LOCK_TIMEOUT_CYCLES-1: increment retry_cnt (saturating), set lock_fail if the new retry_cnt>=MAX_RETRIES, and go to PLL_RST.
  - Retrying continues indefinitely after lock_fail is set.
- STABLE state:
  - sys_rst_n=0.
  - If lock_s=0, go to WAIT_LOCK. The timeout count restarts and the PLL is not reset.
  - When counter==LOCK_STABLE_CYCLES-1 with lock_s=1, go to RUN. sys_rst_n=1 and pll_locked=1 are registered on that same edge.
- RUN state:
  - sys_rst_n=1, pll_locked=1.
  - If lock_s=0, go to WAIT_LOCK. sys_rst_n=0 and pll_locked=0 take effect on the next edge.
  - If stdby_req=1, go to STDBY. If lock loss and stdby_req occur in the same cycle, stdby_req wins.
- STDBY state:
  - pll_stdby=1, pll_reset=0, sys_rst_n=0, pll_locked=0. lock_s is ignored.
  - When stdby_req=0, go to PLL_RST: pll_stdby drops and pll_reset rises on the same edge.
- stdby_req is honoured only in RUN. In every other state it is held off until RUN is reached.
- retry_cnt and lock_fail clear only on rst_n.
- rst_n asserted mid-sequence forces the reset state immediately. After release, the full sequence runs from PLL_RST.
- sys_rst_n deassertion is synchronous to clk. Downstream PLL clock domains must re-synchronise it locally.

Optional Feature:
- Macro: PLL_LOCK_GLITCH_FILTER_EN.
- Defined: in RUN, lock loss is declared only after lock_s has been 0 for GLITCH_CYCLES consecutive cycles; any 1 resets the glitch count. STABLE and WAIT_LOCK are unaffected.
- Undefined: a single low sample of lock_s in RUN triggers lock loss.

Test Plan:
Bench overrides: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=16, MAX_RETRIES=3, GLITCH_CYCLES=4.
1. Release rst_n, then drive extlock=1 at cycle 10 after pll_reset falls -> pll_reset high exactly 4 cycles; sys_rst_n and pll_locked rise on the 19th edge, counting the first edge that samples extlock=1 as edge 1.
2. Hold extlock=0 -> pll_reset re-pulses (4 cycles high) every 36 cycles; retry_cnt goes 1,2,3; lock_fail sets with retry_cnt=3 and stays set; extlock=1 afterwards still reaches RUN.
3. In STABLE, pulse extlock low for 1 cycle at stable count 10 -> back to WAIT_LOCK with no pll_reset pulse; the stable count restarts; sys_rst_n stays 0.
4. In RUN, drop extlock for 1 cycle -> with macro undefined: sys_rst_n falls 3 edges later and the sequence returns via WAIT_LOCK. With PLL_LOCK_GLITCH_FILTER_EN defined: no change; a 4-cycle drop causes lock loss.
5. In RUN, assert stdby_req and drop extlock in the same cycle -> pll_stdby=1, sys_rst_n=0. Release stdby_req -> pll_reset high for 4 cycles, then relock to RUN.
6. Assert rst_n low mid-STABLE -> outputs take reset values immediately; retry_cnt=0, lock_fail=0.
